// File: rtl/sched_pkg.sv
// Shared types and helpers for the round-robin process scheduler.
package sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SAVE,
    S_SELECT,
    S_RESTORE
  } sched_state_t;

  localparam int DEFAULT_QUANTUM = 100;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sched_rr_arbiter.sv
// Rotating first-valid search starting after cur_slot; with SCHED_PRIORITY_EN the
// highest priority wins and rotation order breaks ties.
module sched_rr_arbiter
  import sched_pkg::*;
#(
  parameter int NPROC = 4,
  localparam int IW = idx_w(NPROC)
) (
  input  logic [NPROC-1:0]      valid,
  input  logic [IW-1:0]         cur_slot,
`ifdef SCHED_PRIORITY_EN
  input  logic [NPROC-1:0][1:0] prio,
`endif
  output logic                  found,
  output logic [IW-1:0]         sel
);

  logic [IW-1:0] idx;
`ifdef SCHED_PRIORITY_EN
  logic [1:0]    best;
`endif

  always_comb begin
    found = 1'b0;
    sel   = cur_slot;
    idx   = cur_slot;
`ifdef SCHED_PRIORITY_EN
    best  = 2'd0;
`endif
    // Offset NPROC wraps back to cur_slot itself, so a lone process reselects itself.
    for (int i = 1; i <= NPROC; i++) begin
      idx = IW'((int'(cur_slot) + i) % NPROC);
`ifdef SCHED_PRIORITY_EN
      if (valid[idx] && (!found || prio[idx] > best)) begin
        found = 1'b1;
        sel   = idx;
        best  = prio[idx];
      end
`else
      if (valid[idx] && !found) begin
        found = 1'b1;
        sel   = idx;
      end
`endif
    end
  end

endmodule

// File: rtl/proc_scheduler.sv
// Preemptive round-robin scheduler over NPROC process slots.
// Define SCHED_PRIORITY_EN to add prio_in and priority-aware slot selection.
module proc_scheduler #(
  parameter int NPROC           = 4,
  parameter int ADDR_W          = 32,
  parameter int QUANT_W         = 16,
  parameter int DEFAULT_QUANTUM = sched_pkg::DEFAULT_QUANTUM
) (
  input  logic                                 CLK,
  input  logic                                 reset,
  input  logic                                 set_quantum,
  input  logic [QUANT_W-1:0]                   quantum_in,
  input  logic                                 load_en,
  input  logic [sched_pkg::idx_w(NPROC)-1:0]   load_slot,
  input  logic [ADDR_W-1:0]                    load_base,
`ifdef SCHED_PRIORITY_EN
  input  logic [1:0]                           prio_in,
`endif
  input  logic                                 kill_en,
  input  logic [sched_pkg::idx_w(NPROC)-1:0]   kill_slot,
  input  logic                                 cpu_halt,
  input  logic [ADDR_W-1:0]                    cur_pc,
  input  logic                                 ctx_ack,
  output logic                                 ctx_req,
  output logic                                 resume_valid,
  output logic [ADDR_W-1:0]                    resume_pc,
  output logic [ADDR_W-1:0]                    base_addr,
  output logic [sched_pkg::idx_w(NPROC)-1:0]   cur_slot,
  output logic [QUANT_W-1:0]                   quantum_left,
  output logic                                 idle,
  output logic                                 load_err
);
  import sched_pkg::*;

  localparam int IW = idx_w(NPROC);

  sched_state_t       state_q, state_d;
  logic [NPROC-1:0]   valid_q, valid_d;
  logic [ADDR_W-1:0]  base_q [NPROC];
  logic [ADDR_W-1:0]  base_d [NPROC];
  logic [ADDR_W-1:0]  saved_pc_q [NPROC];
  logic [ADDR_W-1:0]  saved_pc_d [NPROC];
  logic [QUANT_W-1:0] quantum_q, quantum_d;
  logic [QUANT_W-1:0] quantum_left_q, quantum_left_d;
  logic [IW-1:0]      cur_slot_q, cur_slot_d;
  logic               ctx_req_q, ctx_req_d;
  logic               resume_valid_q, resume_valid_d;
  logic [ADDR_W-1:0]  resume_pc_q, resume_pc_d;
  logic [ADDR_W-1:0]  base_addr_q, base_addr_d;
  logic               idle_q, idle_d;
  logic               load_err_q, load_err_d;
`ifdef SCHED_PRIORITY_EN
  logic [NPROC-1:0][1:0] prio_q, prio_d;
`endif

  logic          running;
  logic          arb_found;
  logic [IW-1:0] arb_sel;

  sched_rr_arbiter #(.NPROC(NPROC)) u_arb (
    .valid    (valid_q),
    .cur_slot (cur_slot_q),
`ifdef SCHED_PRIORITY_EN
    .prio     (prio_q),
`endif
    .found    (arb_found),
    .sel      (arb_sel)
  );

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    base_d         = base_q;
    saved_pc_d     = saved_pc_q;
    quantum_d      = quantum_q;
    quantum_left_d = quantum_left_q;
    cur_slot_d     = cur_slot_q;
    ctx_req_d      = 1'b0;
    resume_valid_d = 1'b0;
    resume_pc_d    = resume_pc_q;
    base_addr_d    = base_addr_q;
    load_err_d     = 1'b0;
`ifdef SCHED_PRIORITY_EN
    prio_d         = prio_q;
`endif
    running = (state_q == S_RUN) || (state_q == S_SAVE) || (state_q == S_RESTORE);

    if (set_quantum) quantum_d = (quantum_in == '0) ? QUANT_W'(1) : quantum_in;

    // A load never disturbs the running slot, and a same-cycle kill overrides it.
    if (load_en) begin
      if (running && load_slot == cur_slot_q) begin
        load_err_d = 1'b1;
      end else if (!(kill_en && kill_slot == load_slot)) begin
        valid_d[load_slot]    = 1'b1;
        base_d[load_slot]     = load_base;
        saved_pc_d[load_slot] = load_base;
`ifdef SCHED_PRIORITY_EN
        prio_d[load_slot]     = prio_in;
`endif
      end
    end
    if (kill_en) valid_d[kill_slot] = 1'b0;

    case (state_q)
      S_IDLE: if (|valid_d) state_d = S_SELECT;
      S_RUN: begin
        if (quantum_left_q != '0) quantum_left_d = quantum_left_q - QUANT_W'(1);
        if (cpu_halt || (kill_en && kill_slot == cur_slot_q)) begin
          valid_d[cur_slot_q] = 1'b0;
          state_d             = S_SELECT;
        end else if (quantum_left_q <= QUANT_W'(1)) begin
          state_d   = S_SAVE;
          ctx_req_d = 1'b1;
        end
      end
      S_SAVE: begin
        if (cpu_halt) begin
          valid_d[cur_slot_q] = 1'b0;
          state_d             = S_SELECT;
        end else if (ctx_ack) begin
          saved_pc_d[cur_slot_q] = cur_pc;
          state_d                = S_SELECT;
        end else begin
          ctx_req_d = 1'b1;
        end
      end
      S_SELECT: begin
        if (arb_found) begin
          cur_slot_d     = arb_sel;
          resume_valid_d = 1'b1;
          resume_pc_d    = saved_pc_q[arb_sel];
          base_addr_d    = base_q[arb_sel];
          state_d        = S_RESTORE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESTORE: begin
        quantum_left_d = quantum_q;
        state_d        = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase

    idle_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      valid_q        <= '0;
      for (int i = 0; i < NPROC; i++) begin
        base_q[i]     <= '0;
        saved_pc_q[i] <= '0;
      end
      quantum_q      <= QUANT_W'(DEFAULT_QUANTUM);
      quantum_left_q <= '0;
      cur_slot_q     <= '0;
      ctx_req_q      <= 1'b0;
      resume_valid_q <= 1'b0;
      resume_pc_q    <= '0;
      base_addr_q    <= '0;
      idle_q         <= 1'b1;
      load_err_q     <= 1'b0;
`ifdef SCHED_PRIORITY_EN
      prio_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      base_q         <= base_d;
      saved_pc_q     <= saved_pc_d;
      quantum_q      <= quantum_d;
      quantum_left_q <= quantum_left_d;
      cur_slot_q     <= cur_slot_d;
      ctx_req_q      <= ctx_req_d;
      resume_valid_q <= resume_valid_d;
      resume_pc_q    <= resume_pc_d;
      base_addr_q    <= base_addr_d;
      idle_q         <= idle_d;
      load_err_q     <= load_err_d;
`ifdef SCHED_PRIORITY_EN
      prio_q         <= prio_d;
`endif
    end
  end

  assign ctx_req      = ctx_req_q;
  assign resume_valid = resume_valid_q;
  assign resume_pc    = resume_pc_q;
  assign base_addr    = base_addr_q;
  assign cur_slot     = cur_slot_q;
  assign quantum_left = quantum_left_q;
  assign idle         = idle_q;
  assign load_err     = load_err_q;

endmodule

// File: tb/tb_proc_scheduler.sv
// Scoreboard bench for proc_scheduler: expected resumes are queued by the stimulus
// and popped by a monitor whenever resume_valid is presented.
module tb_proc_scheduler;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        set_quantum = 1'b0;
  logic [15:0] quantum_in = '0;
  logic        load_en = 1'b0;
  logic [1:0]  load_slot = '0;
  logic [31:0] load_base = '0;
`ifdef SCHED_PRIORITY_EN
  logic [1:0]  prio_in = '0;
`endif
  logic        kill_en = 1'b0;
  logic [1:0]  kill_slot = '0;
  logic        cpu_halt = 1'b0;
  logic [31:0] cur_pc = '0;
  logic        ctx_ack = 1'b0;
  logic        ctx_req;
  logic        resume_valid;
  logic [31:0] resume_pc;
  logic [31:0] base_addr;
  logic [1:0]  cur_slot;
  logic [15:0] quantum_left;
  logic        idle;
  logic        load_err;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] base;
    logic [1:0]  slot;
  } exp_t;

  exp_t sbq[$];
  int   checkCount = 0;
  int   passCount = 0;

  proc_scheduler #(.NPROC(4), .ADDR_W(32), .QUANT_W(16), .DEFAULT_QUANTUM(100)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .set_quantum  (set_quantum),
    .quantum_in   (quantum_in),
    .load_en      (load_en),
    .load_slot    (load_slot),
    .load_base    (load_base),
`ifdef SCHED_PRIORITY_EN
    .prio_in      (prio_in),
`endif
    .kill_en      (kill_en),
    .kill_slot    (kill_slot),
    .cpu_halt     (cpu_halt),
    .cur_pc       (cur_pc),
    .ctx_ack      (ctx_ack),
    .ctx_req      (ctx_req),
    .resume_valid (resume_valid),
    .resume_pc    (resume_pc),
    .base_addr    (base_addr),
    .cur_slot     (cur_slot),
    .quantum_left (quantum_left),
    .idle         (idle),
    .load_err     (load_err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic pushExp(input logic [31:0] pc, input logic [31:0] base, input logic [1:0] slot);
    exp_t e;
    e.pc   = pc;
    e.base = base;
    e.slot = slot;
    sbq.push_back(e);
  endtask

  // Monitor: every resume pulse must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (reset && resume_valid) begin
      if (sbq.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_resume: got resume_pc %0h slot %0d, expected no resume",
                 resume_pc, cur_slot);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput("resume_pc", resume_pc, e.pc);
        checkOutput("resume_base", base_addr, e.base);
        checkOutput("resume_slot", 32'(cur_slot), 32'(e.slot));
      end
    end
  end

  // Drives one load for a single cycle starting at the current negedge.
  task automatic applyLoad(input logic [1:0] s, input logic [31:0] b);
    load_en   = 1'b1;
    load_slot = s;
    load_base = b;
    @(negedge CLK);
    load_en   = 1'b0;
  endtask

  // Called at the RESTORE negedge; counts RUN cycles until ctx_req appears,
  // optionally issuing set_quantum after sqAt RUN cycles.
  task automatic runUntilReq(output int cnt, output int ql0, input int sqAt, input logic [15:0] sqVal);
    bit done;
    done = 1'b0;
    cnt  = 0;
    ql0  = -1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge CLK);
      set_quantum = 1'b0;
      if (k == 0) ql0 = int'(quantum_left);
      if (ctx_req) done = 1'b1;
      else begin
        cnt++;
        if (cnt == sqAt) begin
          set_quantum = 1'b1;
          quantum_in  = sqVal;
        end
      end
    end
    set_quantum = 1'b0;
    checkOutput("ctx_req_seen", 32'(done), 32'd1);
  endtask

  // Called at a SAVE negedge; acknowledges and expects resume two cycles later.
  task automatic applyAck(input logic [31:0] pc);
    ctx_ack = 1'b1;
    cur_pc  = pc;
    @(negedge CLK);
    ctx_ack = 1'b0;
    checkOutput("ack_ctx_req_drop", 32'(ctx_req), 32'd0);
    checkOutput("ack_select_no_resume", 32'(resume_valid), 32'd0);
    @(negedge CLK);
    checkOutput("ack_resume_latency", 32'(resume_valid), 32'd1);
  endtask

  initial begin
    int cnt;
    int ql0;

    repeat (2) @(negedge CLK);
    checkOutput("rst_idle", 32'(idle), 32'd1);
    checkOutput("rst_ctx_req", 32'(ctx_req), 32'd0);
    checkOutput("rst_resume_valid", 32'(resume_valid), 32'd0);
    checkOutput("rst_cur_slot", 32'(cur_slot), 32'd0);
    checkOutput("rst_quantum_left", 32'(quantum_left), 32'd0);
    checkOutput("rst_load_err", 32'(load_err), 32'd0);
    checkOutput("rst_resume_pc", resume_pc, 32'd0);
    checkOutput("rst_base_addr", base_addr, 32'd0);

    reset       = 1'b1;
    set_quantum = 1'b1;
    quantum_in  = 16'd4;
    @(negedge CLK);
    set_quantum = 1'b0;

    pushExp(32'h100, 32'h100, 2'd0);
    applyLoad(2'd0, 32'h100);
    applyLoad(2'd1, 32'h200);
    checkOutput("load_resume_latency", 32'(resume_valid), 32'd1);

    runUntilReq(cnt, ql0, -1, 16'd0);
    checkOutput("q4_run_len_s0", 32'(cnt), 32'd4);
    checkOutput("q4_start_s0", 32'(ql0), 32'd4);
    pushExp(32'h200, 32'h200, 2'd1);
    applyAck(32'h110);

    runUntilReq(cnt, ql0, -1, 16'd0);
    checkOutput("q4_run_len_s1", 32'(cnt), 32'd4);
    pushExp(32'h110, 32'h100, 2'd0);
    applyAck(32'h208);

    runUntilReq(cnt, ql0, -1, 16'd0);
    pushExp(32'h208, 32'h200, 2'd1);
    applyAck(32'h120);

    // Halt slot 1 in its first RUN cycle: no save, straight to slot 0.
    @(negedge CLK);
    cpu_halt = 1'b1;
    pushExp(32'h120, 32'h100, 2'd0);
    @(negedge CLK);
    cpu_halt = 1'b0;
    checkOutput("halt_no_ctx_req", 32'(ctx_req), 32'd0);
    checkOutput("halt_select_no_resume", 32'(resume_valid), 32'd0);
    @(negedge CLK);
    checkOutput("halt_resume", 32'(resume_valid), 32'd1);

    runUntilReq(cnt, ql0, -1, 16'd0);
    pushExp(32'h130, 32'h100, 2'd0);
    applyAck(32'h130);

    @(negedge CLK);
    cpu_halt = 1'b1;
    @(negedge CLK);
    cpu_halt = 1'b0;
    checkOutput("last_halt_select_idle", 32'(idle), 32'd0);
    @(negedge CLK);
    checkOutput("last_halt_idle", 32'(idle), 32'd1);
    checkOutput("last_halt_ctx_req", 32'(ctx_req), 32'd0);

    pushExp(32'h300, 32'h300, 2'd3);
    applyLoad(2'd3, 32'h300);
    @(negedge CLK);
    checkOutput("load3_resume_latency", 32'(resume_valid), 32'd1);

    runUntilReq(cnt, ql0, 1, 16'd8);
    checkOutput("setq_no_truncate", 32'(cnt), 32'd4);
    pushExp(32'h340, 32'h300, 2'd3);
    applyAck(32'h340);

    runUntilReq(cnt, ql0, 1, 16'd0);
    checkOutput("setq8_run_len", 32'(cnt), 32'd8);
    checkOutput("setq8_start", 32'(ql0), 32'd8);
    pushExp(32'h350, 32'h300, 2'd3);
    applyAck(32'h350);

    runUntilReq(cnt, ql0, -1, 16'd0);
    checkOutput("q0_run_len", 32'(cnt), 32'd1);
    checkOutput("q0_start", 32'(ql0), 32'd1);
    checkOutput("save_ctx_req_held", 32'(ctx_req), 32'd1);

    reset = 1'b0;
    #1;
    checkOutput("midsave_rst_ctx_req", 32'(ctx_req), 32'd0);
    checkOutput("midsave_rst_idle", 32'(idle), 32'd1);
    checkOutput("midsave_rst_cur_slot", 32'(cur_slot), 32'd0);
    checkOutput("midsave_rst_quantum_left", 32'(quantum_left), 32'd0);
    checkOutput("midsave_rst_resume_pc", resume_pc, 32'd0);
    checkOutput("midsave_rst_base_addr", base_addr, 32'd0);
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);

    pushExp(32'h400, 32'h400, 2'd2);
    applyLoad(2'd2, 32'h400);
    @(negedge CLK);
    checkOutput("post_rst_resume", 32'(resume_valid), 32'd1);

    // Load aimed at the running slot during RESTORE must be rejected.
    load_en   = 1'b1;
    load_slot = 2'd2;
    load_base = 32'h999;
    @(negedge CLK);
    load_en = 1'b0;
    checkOutput("load_err_pulse", 32'(load_err), 32'd1);
    @(negedge CLK);
    checkOutput("load_err_clear", 32'(load_err), 32'd0);

    applyLoad(2'd0, 32'h500);
    runUntilReq(cnt, ql0, -1, 16'd0);
    checkOutput("default_q_remaining", 32'(cnt), 32'd97);
    pushExp(32'h500, 32'h500, 2'd0);
    applyAck(32'h420);

    runUntilReq(cnt, ql0, -1, 16'd0);
    checkOutput("default_q_run_len", 32'(cnt), 32'd100);
    pushExp(32'h420, 32'h400, 2'd2);
    applyAck(32'h510);

    repeat (3) @(negedge CLK);
    checkOutput("sb_empty", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
